// File: rtl/score_time_display_pkg.sv
// Shared constants for the score/time seven-segment driver: active-low
// segment patterns {g,f,e,d,c,b,a}, digit indices and conversion FSM states.
package score_time_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam logic [1:0] DIG_S_ONES = 2'd0;
    localparam logic [1:0] DIG_S_TENS = 2'd1;
    localparam logic [1:0] DIG_T_ONES = 2'd2;
    localparam logic [1:0] DIG_T_TENS = 2'd3;

    localparam int TIME_MAX = 99;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT_S = 2'd1,
        ST_SHIFT_T = 2'd2,
        ST_COMMIT  = 2'd3
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/score_time_display_bin2bcd_shift.sv
// Sequential double-dabble: one add-3-then-shift step per i_shift, two BCD
// digits out. Exposes the post-step value so the caller can latch on the last step.
module score_time_display_bin2bcd_shift #(
    parameter int BIN_W = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [BIN_W-1:0] i_bin,
    output logic [3:0]       o_tens_nxt,
    output logic [3:0]       o_ones_nxt,
    output logic             o_last
);
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] r_bin;
    logic [3:0]       r_tens;
    logic [3:0]       r_ones;
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]       w_tens_adj;
    logic [3:0]       w_ones_adj;
    logic [BIN_W+7:0] w_shifted;

    assign w_tens_adj = (r_tens >= 4'd5) ? r_tens + 4'd3 : r_tens;
    assign w_ones_adj = (r_ones >= 4'd5) ? r_ones + 4'd3 : r_ones;
    // Values never exceed 99, so the bit leaving the tens digit is always 0.
    assign w_shifted  = {w_tens_adj[2:0], w_ones_adj, r_bin, 1'b0};

    assign o_tens_nxt = w_shifted[BIN_W+7:BIN_W+4];
    assign o_ones_nxt = w_shifted[BIN_W+3:BIN_W];
    assign o_last     = (r_cnt == CNT_W'(BIN_W - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bin  <= '0;
            r_tens <= '0;
            r_ones <= '0;
            r_cnt  <= '0;
        end else if (i_load) begin
            r_bin  <= i_bin;
            r_tens <= '0;
            r_ones <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_bin  <= w_shifted[BIN_W-1:0];
            r_tens <= o_tens_nxt;
            r_ones <= o_ones_nxt;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/score_time_display.sv
// Four-digit common-anode driver: time remaining on the left pair, score on the
// right pair; values converted to BCD serially and committed to the display atomically.
module score_time_display
    import score_time_display_pkg::*;
#(
    parameter int SCORE_W      = 6,
    parameter int TIME_W       = 7,
    parameter int SHIFT_CYCLES = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              displayTick,
    input  logic              displayEnable,
    input  logic [SCORE_W-1:0] score,
    input  logic [TIME_W-1:0]  timeLeft,
    output logic [3:0]        anode,
    output logic [6:0]        segment,
    output logic              convBusy
);
    conv_state_t r_state, w_state_nxt;

    logic [SCORE_W-1:0]      r_snap_score;
    logic [TIME_W-1:0]       r_snap_time;
    logic [3:0]              r_pend_s_tens, r_pend_s_ones, r_pend_t_tens, r_pend_t_ones;
    logic [3:0]              r_disp_s_tens, r_disp_s_ones, r_disp_t_tens, r_disp_t_ones;
    logic [1:0]              r_idx;
    logic [3:0]              r_anode;
    logic [6:0]              r_segment;

    logic [TIME_W-1:0]       w_time_sat;
    logic                    w_mismatch;
    logic                    w_load, w_shift, w_capture, w_latch_s, w_latch_t, w_commit;
    logic [SHIFT_CYCLES-1:0] w_eng_bin;
    logic [3:0]              w_eng_tens, w_eng_ones;
    logic                    w_eng_last;
    logic [1:0]              w_idx_nxt;
    logic [3:0]              w_anode_nxt;
    logic [6:0]              w_seg_nxt;

    // Saturate before the compare so 100..127 all look identical to the FSM.
    assign w_time_sat = (timeLeft > TIME_W'(TIME_MAX)) ? TIME_W'(TIME_MAX) : timeLeft;
    assign w_mismatch = ({score, w_time_sat} != {r_snap_score, r_snap_time});
    assign convBusy   = (r_state != ST_IDLE);

    // Score loads straight from the port on the capture edge; time from the snapshot later.
    assign w_eng_bin = (r_state == ST_IDLE) ? SHIFT_CYCLES'(score) : SHIFT_CYCLES'(r_snap_time);

    score_time_display_bin2bcd_shift #(
        .BIN_W (SHIFT_CYCLES)
    ) u_bcd (
        .clock      (clock),
        .reset      (reset),
        .i_load     (w_load),
        .i_shift    (w_shift),
        .i_bin      (w_eng_bin),
        .o_tens_nxt (w_eng_tens),
        .o_ones_nxt (w_eng_ones),
        .o_last     (w_eng_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_capture   = 1'b0;
        w_latch_s   = 1'b0;
        w_latch_t   = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_mismatch) begin
                    w_capture   = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT_S;
                end
            end
            ST_SHIFT_S: begin
                w_shift = 1'b1;
                if (w_eng_last) begin
                    w_latch_s   = 1'b1;
                    w_load      = 1'b1;
                    w_state_nxt = ST_SHIFT_T;
                end
            end
            ST_SHIFT_T: begin
                w_shift = 1'b1;
                if (w_eng_last) begin
                    w_latch_t   = 1'b1;
                    w_state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_snap_score  <= '0;
            r_snap_time   <= '0;
            r_pend_s_tens <= '0;
            r_pend_s_ones <= '0;
            r_pend_t_tens <= '0;
            r_pend_t_ones <= '0;
            r_disp_s_tens <= '0;
            r_disp_s_ones <= '0;
            r_disp_t_tens <= '0;
            r_disp_t_ones <= '0;
        end else begin
            if (w_capture) begin
                r_snap_score <= score;
                r_snap_time  <= w_time_sat;
            end
            if (w_latch_s) begin
                r_pend_s_tens <= w_eng_tens;
                r_pend_s_ones <= w_eng_ones;
            end
            if (w_latch_t) begin
                r_pend_t_tens <= w_eng_tens;
                r_pend_t_ones <= w_eng_ones;
            end
            // All four digits change together so a half-updated pair is never shown.
            if (w_commit) begin
                r_disp_s_tens <= r_pend_s_tens;
                r_disp_s_ones <= r_pend_s_ones;
                r_disp_t_tens <= r_pend_t_tens;
                r_disp_t_ones <= r_pend_t_ones;
            end
        end
    end

    assign w_idx_nxt   = r_idx + 2'd1;
    assign w_anode_nxt = ~(4'b0001 << w_idx_nxt);

    always_comb begin
        w_seg_nxt = SEG_BLANK;
        case (w_idx_nxt)
            DIG_T_TENS: w_seg_nxt = (r_disp_t_tens == 4'd0) ? SEG_BLANK : seg_decode(r_disp_t_tens);
            DIG_T_ONES: w_seg_nxt = seg_decode(r_disp_t_ones);
            DIG_S_TENS: w_seg_nxt = (r_disp_s_tens == 4'd0) ? SEG_BLANK : seg_decode(r_disp_s_tens);
            DIG_S_ONES: w_seg_nxt = seg_decode(r_disp_s_ones);
            default:    w_seg_nxt = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_idx     <= 2'd0;
            r_anode   <= ANODE_OFF;
            r_segment <= SEG_BLANK;
        end else if (displayTick) begin
            r_idx <= w_idx_nxt;
            if (displayEnable) begin
                r_anode   <= w_anode_nxt;
                r_segment <= w_seg_nxt;
            end else begin
                r_anode   <= ANODE_OFF;
                r_segment <= SEG_BLANK;
            end
        end
    end

    assign anode   = r_anode;
    assign segment = r_segment;

endmodule

// File: tb/tb_score_time_display.sv
// Directed bench for score_time_display: reset state, conversion timing,
// scan order, blanking, saturation, mid-conversion input changes and enable.
module tb_score_time_display;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S7 = 7'h78, S9 = 7'h10, SB = 7'h7F;

    logic       clock = 1'b0;
    logic       reset;
    logic       displayTick;
    logic       displayEnable;
    logic [5:0] score;
    logic [6:0] timeLeft;
    logic [3:0] anode;
    logic [6:0] segment;
    logic       convBusy;

    int vectors    = 0;
    int miscompares = 0;

    score_time_display dut (
        .clock         (clock),
        .reset         (reset),
        .displayTick   (displayTick),
        .displayEnable (displayEnable),
        .score         (score),
        .timeLeft      (timeLeft),
        .anode         (anode),
        .segment       (segment),
        .convBusy      (convBusy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick_chk(input string tag, input logic [3:0] exp_an, input logic [6:0] exp_seg);
        @(negedge clock) displayTick = 1'b1;
        @(negedge clock) displayTick = 1'b0;
        chk({tag, "_anode"}, {3'b000, anode}, {3'b000, exp_an});
        chk({tag, "_seg"}, segment, exp_seg);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; displayTick = 1'b0; displayEnable = 1'b0;
        score = 6'd5; timeLeft = 7'd30;

        // Reset state
        wait_cyc(2);
        chk("rst_anode", {3'b000, anode}, 7'h0F);
        chk("rst_seg", segment, SB);
        chk("rst_busy", {6'd0, convBusy}, 7'd0);

        // Release: busy for exactly 15 clocks starting at the first edge
        reset = 1'b0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock);
            chk($sformatf("boot_busy_%0d", k), {6'd0, convBusy}, (k < 15) ? 7'd1 : 7'd0);
        end

        // Display {3,0,_,5}: index 0 -> 1,2,3,0
        displayEnable = 1'b1;
        tick_chk("boot_d1", 4'b1101, SB);
        tick_chk("boot_d2", 4'b1011, S0);
        tick_chk("boot_d3", 4'b0111, S3);
        tick_chk("boot_d0", 4'b1110, S5);

        // score 42, time 57
        score = 6'd42; timeLeft = 7'd57;
        wait_cyc(20);
        chk("s42_idle", {6'd0, convBusy}, 7'd0);
        tick_chk("s42_pre1", 4'b1101, S4);
        tick_chk("s42_pre2", 4'b1011, S7);
        tick_chk("s42_pre3", 4'b0111, S5);
        tick_chk("s42_d0", 4'b1110, S2);
        tick_chk("s42_d1", 4'b1101, S4);
        tick_chk("s42_d2", 4'b1011, S7);
        tick_chk("s42_d3", 4'b0111, S5);
        wait_cyc(3);
        chk("hold_anode", {3'b000, anode}, 7'h07);
        chk("hold_seg", segment, S5);

        // Leading-zero blanking: score 7, time 9
        score = 6'd7; timeLeft = 7'd9;
        wait_cyc(20);
        tick_chk("lz_d0", 4'b1110, S7);
        tick_chk("lz_d1", 4'b1101, SB);
        tick_chk("lz_d2", 4'b1011, S9);
        tick_chk("lz_d3", 4'b0111, SB);

        // Saturation
        timeLeft = 7'd120;
        @(negedge clock);
        chk("sat_busy", {6'd0, convBusy}, 7'd1);
        wait_cyc(20);
        tick_chk("sat_d0", 4'b1110, S7);
        tick_chk("sat_d1", 4'b1101, SB);
        tick_chk("sat_d2", 4'b1011, S9);
        tick_chk("sat_d3", 4'b0111, S9);
        timeLeft = 7'd100;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            chk("sat_noretrig", {6'd0, convBusy}, 7'd0);
        end

        // Mid-conversion change: 9 -> 10 starts at E, 11 arrives before E+3
        score = 6'd9;
        wait_cyc(20);
        score = 6'd10;
        @(negedge clock);
        chk("mid_busy_E", {6'd0, convBusy}, 7'd1);
        wait_cyc(2);
        score = 6'd11;
        wait_cyc(12);
        displayTick = 1'b1;
        @(negedge clock);
        chk("mid_E15_anode", {3'b000, anode}, 7'h0E);
        chk("mid_E15_seg", segment, S9);
        chk("mid_E15_busy", {6'd0, convBusy}, 7'd0);
        @(negedge clock);
        displayTick = 1'b0;
        chk("mid_E16_anode", {3'b000, anode}, 7'h0D);
        chk("mid_E16_seg", segment, S1);
        chk("mid_E16_busy", {6'd0, convBusy}, 7'd1);
        wait_cyc(14);
        chk("mid_E30_busy", {6'd0, convBusy}, 7'd1);
        @(negedge clock);
        chk("mid_E31_busy", {6'd0, convBusy}, 7'd0);
        tick_chk("mid_d2", 4'b1011, S9);
        tick_chk("mid_d3", 4'b0111, S9);
        tick_chk("mid_d0", 4'b1110, S1);
        tick_chk("mid_d1", 4'b1101, S1);

        // Enable off then on: scan index keeps moving, no conversion restart
        displayEnable = 1'b0;
        tick_chk("dis_d2", 4'b1111, SB);
        tick_chk("dis_d3", 4'b1111, SB);
        chk("dis_busy", {6'd0, convBusy}, 7'd0);
        displayEnable = 1'b1;
        tick_chk("en_d0", 4'b1110, S1);
        chk("en_busy", {6'd0, convBusy}, 7'd0);
        tick_chk("en_d1", 4'b1101, S1);

        // Reset mid-conversion
        score = 6'd20;
        wait_cyc(5);
        reset = 1'b1;
        #1;
        chk("midrst_anode", {3'b000, anode}, 7'h0F);
        chk("midrst_seg", segment, SB);
        chk("midrst_busy", {6'd0, convBusy}, 7'd0);
        score = 6'd0; timeLeft = 7'd0;
        wait_cyc(2);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("postrst_busy", {6'd0, convBusy}, 7'd0);
        end
        tick_chk("postrst_d1", 4'b1101, SB);
        tick_chk("postrst_d2", 4'b1011, S0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_time_display.md
Name: score_time_display

Overview:
- Seven-segment display driver downstream of the game FSM and the round timer.
- Shows time remaining on the two left digits and the current score on the two right digits of the 4-digit common-anode display.
- Converts each binary value to BCD with a sequential double-dabble engine.
- Multiplexes the four digits on the 1 kHz scan strobe.

Parameters:
- SCORE_W, 6, width of score input.
- TIME_W, 7, width of timeLeft input.
- SHIFT_CYCLES, 7, double-dabble iterations per value (= max(SCORE_W, TIME_W)).

Ports:
- clock  input  1  100 MHz system clock.
- reset  input  1  asynchronous, active-high reset.
- displayTick  input  1  one-clock-wide scan strobe at 1 kHz, synchronous to clock.
- displayEnable  input  1  high while the game is active or the result is shown; low blanks all digits.
- score  input  6  binary score, 0..63.
- timeLeft  input  7  binary seconds remaining, 0..127; values above 99 saturate to 99.
- anode  output  4  active-low digit enables; [3] is leftmost.
- segment  output  7  active-low segments {g,f,e,d,c,b,a}.
- convBusy  output  1  high while a conversion is in progress.

Behaviour:
- Reset (async, immediate) sets:
  - anode=4'b1111, segment=7'b1111111, convBusy=0.
  - scan index=0, FSM=IDLE.
  - snapshot regs=0, all four BCD display regs=0.
- Conversion FSM states: IDLE, SHIFT_S, SHIFT_T, COMMIT.
- IDLE:
  - Each edge, compare {score, saturated timeLeft} against the snapshot.
  - On mismatch: capture both into the snapshot, load score into the shift engine, go to SHIFT_S, set convBusy=1.
  - Call this edge E.
- SHIFT_S:
  - Runs 7 shift edges, E+1..E+7; add-3 correction is applied before each shift.
  - At E+7: latch score BCD into a pending reg, load the time snapshot, go to SHIFT_T.
- SHIFT_T:
  - Runs 7 shift edges, E+8..E+14.
  - At E+14: latch time BCD into a pending reg, go to COMMIT.
- COMMIT:
  - At E+15: copy both pending pairs into the display BCD regs atomically, convBusy=0, go to IDLE.
  - No torn update is ever displayed.
- Input changes during a conversion are ignored; the snapshot is used throughout.
- The next IDLE edge (E+16) re-detects any remaining mismatch, so a minimum of 16 clocks separates conversion starts.
- Saturation is combinational before comparison, so timeLeft 100..127 all read as 99 and do not retrigger among themselves.
- Scan:
  - 2-bit index increments (wraps 3->0) on each clock edge with displayTick=1.
  - anode and segment are registered and updated on that same edge from the new index, so there is one clock of latency from the strobe.
  - Without a tick, outputs hold.
- Digit map: index 3 = time tens, 2 = time ones, 1 = score tens, 0 = score ones.
- Leading-zero blanking: time tens=0 or score tens=0 drives segment=7'b1111111 for that digit; its anode is still driven low.
- displayEnable=0:
  - anode=4'b1111 and segment=7'b1111111 on the next scan-update edge.
  - Scan index and conversion keep running.
- Decoder: BCD 0..9 map to standard patterns; codes 10..15 cannot occur and decode to blank.
- Reset mid-conversion aborts to IDLE with display regs zero. With inputs nonzero after reset, a conversion starts on the first edge after reset deasserts.

Decomposition:
- Shared package: segment pattern constants for 0..9 and BLANK, ANODE_OFF, digit index constants, FSM state encoding.
- One natural sub-module: bin2bcd_shift, a 7-bit to 2-digit sequential double-dabble with load/shift/done.
- The scan counter, FSM and decoder stay in the top.

Test Plan:
- Reset held, score=5, timeLeft=30 -> anode=1111, segment=1111111, convBusy=0. Release reset -> convBusy high 15 clocks; display regs {3,0,0,5} exactly 16 edges after the first sampling edge.
- Enable=1, 4 ticks, score=42, timeLeft=57 -> anode sequence 1110 (seg 2), 1101 (4), 1011 (7), 0111 (5), each one clock after its tick.
- score=7, timeLeft=9 -> digits 3 and 1 blank (segment=1111111, anode low), digits 2/0 show 9/7.
- timeLeft=120 -> time digits show 9,9. Then timeLeft=100 -> no new conversion (convBusy stays 0).
- Change score 10->11 at E+3 of a conversion started by 9->10 -> display shows 10 at E+15, then 11 at E+31.
- displayEnable=0 mid-game with ticks -> anode=1111 from the next tick-edge. Re-enable -> resumes at the current scan index with no conversion restart.
